// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - boot sequencer that streams a checksummed image into the HACK ROM
// Frame: SYNC, CNT_HI, CNT_LO, CNT x (hi, lo), SUM_HI, SUM_LO; the CPU stays held until the sum matches.
module hack_rom_loader #(
  parameter int          MAX_WORDS = 16384,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        rom_load,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO,
    ST_WRITE, ST_SUM_HI, ST_SUM_LO, ST_DONE, ST_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic          in_ready_q, rom_load_q, cpu_hold_q, done_q, error_q;
  logic [14:0]   addr_q;
  logic [15:0]   data_q;
  logic [15:0]   sum_q;
  logic [15:0]   rem_q;
  logic [7:0]    hi_q;
  logic [TW-1:0] tmo_q;

  logic        xfer, is_sync, active;
  logic [15:0] rx_word;

  always_comb begin
    xfer    = in_valid & in_ready_q;
    is_sync = (in_data == SYNC_BYTE);
    rx_word = {hi_q, in_data};
    active  = (state_q == ST_CNT_HI) || (state_q == ST_CNT_LO) ||
              (state_q == ST_DAT_HI) || (state_q == ST_DAT_LO) ||
              (state_q == ST_SUM_HI) || (state_q == ST_SUM_LO);
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: if (xfer && is_sync) state_d = ST_CNT_HI;
      ST_CNT_HI: if (xfer) state_d = ST_CNT_LO;
      ST_CNT_LO: if (xfer) begin
        if (rx_word[15] || ({1'b0, rx_word} > MAX_W)) state_d = ST_ERROR;
        else if (rx_word == 16'd0)                     state_d = ST_SUM_HI;
        else                                           state_d = ST_DAT_HI;
      end
      ST_DAT_HI: if (xfer) state_d = ST_DAT_LO;
      ST_DAT_LO: if (xfer) state_d = ST_WRITE;
      ST_WRITE:  state_d = (rem_q == 16'd1) ? ST_SUM_HI : ST_DAT_HI;
      ST_SUM_HI: if (xfer) state_d = ST_SUM_LO;
      ST_SUM_LO: if (xfer) state_d = (rx_word == sum_q) ? ST_DONE : ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase
    // An idle stream mid-frame aborts the load; a byte on the same edge wins.
    if (active && !xfer && (tmo_q == TMO_LAST)) state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      rom_load_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sum_q      <= '0;
      rem_q      <= '0;
      hi_q       <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_WRITE);
      rom_load_q <= (state_d == ST_WRITE);
      done_q     <= (state_d == ST_DONE);
      error_q    <= (state_d == ST_ERROR);
      // Release lags DONE by one cycle; a restart re-asserts hold on the same edge.
      cpu_hold_q <= !((state_q == ST_DONE) && (state_d == ST_DONE));
      tmo_q      <= (active && !xfer) ? tmo_q + TW'(1) : '0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: if (state_d == ST_CNT_HI) begin
          addr_q <= '0;
          sum_q  <= '0;
        end
        ST_CNT_HI, ST_DAT_HI, ST_SUM_HI: if (xfer) hi_q <= in_data;
        ST_CNT_LO: if (xfer) rem_q <= rx_word;
        ST_DAT_LO: if (xfer) data_q <= rx_word;
        ST_WRITE: begin
          sum_q  <= sum_q + data_q;
          rem_q  <= rem_q - 16'd1;
          addr_q <= addr_q + 15'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign rom_load = rom_load_q;
  assign rom_addr = addr_q;
  assign rom_data = data_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Boot-time sequencer that fills the HACK instruction ROM from a byte stream, for example a UART receiver.
- Drives the ROM write port: load strobe, control address and data word.
- Holds the CPU in reset until a complete, checksum-verified image is in ROM, then releases it.
- Sits between the byte source and the computer top level; its cpu_hold output feeds the CPU reset OR together with rom_load.

Parameters:
- MAX_WORDS, 16384: largest accepted image in 16-bit words; a larger header count is an error.
- TIMEOUT, 1000000: idle cycles allowed between accepted bytes mid-load before aborting.
- SYNC_BYTE, 8'hA5: byte that starts a load.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data is valid
- in_ready  output  1  loader accepts the byte this cycle (transfer = in_valid & in_ready)
- rom_load  output  1  ROM write strobe, one cycle per word
- rom_addr  output  15  ROM write address
- rom_data  output  16  ROM write data
- cpu_hold  output  1  keeps the CPU in reset
- done  output  1  a valid image is loaded
- error  output  1  last load failed

Behaviour:
- Stream format: SYNC, CNT_HI, CNT_LO, then CNT words of two bytes each (high byte first), then SUM_HI, SUM_LO.
  - CNT is 16 bits; bit 15 must be 0.
  - SUM is the sum of all words, modulo 2^16.
- State machine states: IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, SUM_HI, SUM_LO, DONE, ERROR.
- Reset:
  - state = IDLE.
  - cpu_hold = 1; rom_load = 0; rom_addr = 0; rom_data = 0; done = 0; error = 0.
  - Internal word counter, running sum and timeout counter are cleared.
- in_ready:
  - 1 in every state except WRITE.
  - In WRITE it is 0, so exactly one word is written per pair of bytes.
- IDLE: non-SYNC bytes are accepted and discarded. SYNC -> CNT_HI, which clears the address, sum and error.
- CNT_HI and CNT_LO latch the count bytes. Leaving CNT_LO:
  - count > MAX_WORDS or bit 15 set -> ERROR.
  - count == 0 -> SUM_HI.
  - otherwise -> DAT_HI.
- DAT_HI latches the high byte. DAT_LO latches the low byte -> WRITE.
- WRITE lasts exactly 1 cycle:
  - rom_load = 1, with rom_addr and rom_data stable throughout that cycle.
  - sum += word (16-bit wrap).
  - Next cycle: rom_addr increments, and the state goes to SUM_HI if this was the last word, else DAT_HI.
- Address:
  - First word goes to address 0.
  - The word at index i goes to address i.
  - rom_addr holds its last value outside WRITE.
  - It never wraps, because the count is bounded by MAX_WORDS.
- SUM_HI, then SUM_LO. On SUM_LO, a received SUM equal to the running sum -> DONE, else -> ERROR.
- DONE: done = 1, cpu_hold = 0, error = 0.
- ERROR: error = 1, done = 0, cpu_hold = 1.
- cpu_hold is 1 in every state except DONE. It is registered, so it deasserts on the cycle after the state becomes DONE.
- Restart:
  - In DONE or ERROR, a SYNC byte -> CNT_HI. In that same cycle cpu_hold goes to 1 and done and error go to 0.
  - Other bytes are ignored.
- Timeout:
  - The counter runs in CNT_HI through SUM_LO.
  - It clears on every accepted byte and in WRITE.
  - Reaching TIMEOUT -> ERROR.
  - It is inactive in IDLE, DONE and ERROR.
- A SYNC value mid-load is treated as data, not as a restart.
- rst asserted mid-load returns to IDLE with the reset values next cycle. ROM contents already written are not touched.
- All outputs are registered. Latency from the last data byte transfer to its rom_load cycle is 1 cycle.

Test Plan:
- Reset, then stream A5 00 02 12 34 AB CD BE 01 -> rom_load pulses twice: addr 0 data 1234, then addr 1 data ABCD. done = 1, cpu_hold = 0, error = 0.
- Same stream with a bad checksum (BE 02) -> both words are written, but error = 1, cpu_hold stays 1 and done = 0.
- Stream A5 00 00 00 00 -> no rom_load, and the loader goes to DONE.
- Header A5 40 01 (count 16385) -> ERROR immediately after CNT_LO; no rom_load.
- With TIMEOUT = 16, stream A5 00 03 12, then stall for 16 cycles -> ERROR; cpu_hold remains 1.
- After DONE, send A5 -> cpu_hold rises next cycle and done falls. Then assert rst mid-load -> IDLE, cpu_hold = 1, rom_addr = 0.
- Throughout all scenarios, check that in_ready is 0 in every WRITE cycle.
